// File: rtl/auth_resp_arbiter_pkg.sv
// Shared types and defaults for the authentication responder arbiter.
// Optional feature macro used by the arbiter: AUTH_ARB_TIMEOUT_EN.
package auth_resp_arbiter_pkg;

    // Default message width and responder timeout
    localparam int MSG_LEN          = 8;
    localparam int AUTH_ARB_TIMEOUT = 1024;

    // Arbiter FSM encodings (IDLE=0, WAIT=1, DONE=2, RELEASE=3)
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_DONE    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Two-way round-robin choice: the sole requester wins, a tie goes to
    // the initiator that was not served last.
    function automatic logic rr_winner(input logic req0, input logic req1,
                                       input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/auth_resp_arbiter_if.sv
// Bundle of initiator, response and responder handshake signals.
// slave: arbiter side; master: initiators/responder side.
interface auth_resp_arbiter_if
    import auth_resp_arbiter_pkg::*;
#(
    parameter int MSG_W = MSG_LEN
);
    logic             req0_in;
    logic [MSG_W-1:0] msg0_in;
    logic             ack0_out;
    logic             req1_in;
    logic [MSG_W-1:0] msg1_in;
    logic             ack1_out;
    logic [MSG_W-1:0] rsp_msg_out;
    logic             rsp_err_out;
    logic             busy_out;
    logic             resp_req_out;
    logic [MSG_W-1:0] auth_msg_req_out;
    logic             Ack_in;
    logic [MSG_W-1:0] auth_msg_resp_in;

    modport slave (
        input  req0_in, msg0_in, req1_in, msg1_in, Ack_in, auth_msg_resp_in,
        output ack0_out, ack1_out, rsp_msg_out, rsp_err_out, busy_out,
               resp_req_out, auth_msg_req_out
    );

    modport master (
        output req0_in, msg0_in, req1_in, msg1_in, Ack_in, auth_msg_resp_in,
        input  ack0_out, ack1_out, rsp_msg_out, rsp_err_out, busy_out,
               resp_req_out, auth_msg_req_out
    );
endinterface

// File: rtl/auth_resp_arbiter_rr_pick.sv
// Combinational 2-way round-robin select.
module auth_rr_pick
    import auth_resp_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);
    // Any request makes a grant possible; winner resolves ties fairly
    always_comb begin
        valid  = req0 | req1;
        winner = rr_winner(req0, req1, last_grant);
    end
endmodule

// File: rtl/auth_resp_arbiter.sv
// Shares one authentication responder between two initiators.
// Round-robin grant, req/Ack handshake to the responder, one-cycle ack back
// to the winner. Optional responder timeout enabled by AUTH_ARB_TIMEOUT_EN.
module auth_resp_arbiter
    import auth_resp_arbiter_pkg::*;
#(
    parameter int MSG_W       = MSG_LEN,
    parameter int TIMEOUT_CYC = AUTH_ARB_TIMEOUT,
    parameter int CNT_W       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    auth_resp_arbiter_if.slave   bus
);
    // Reject a counter too narrow to reach the timeout count
    if (CNT_W < 1 || (2 ** CNT_W) < TIMEOUT_CYC) begin : g_bad_cfg
        $error("auth_resp_arbiter: CNT_W too small for TIMEOUT_CYC");
    end

    arb_state_t       state_reg, state_next;
    logic             grant_reg;
    logic             last_grant_reg;
    logic [MSG_W-1:0] auth_msg_reg;
    logic [MSG_W-1:0] rsp_msg_reg;
    logic             pick_valid;
    logic             pick_winner;
    logic             expire;

    auth_rr_pick u_pick (
        .req0       (bus.req0_in),
        .req1       (bus.req1_in),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

`ifdef AUTH_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             rsp_err_reg;

    // An Ack arriving in the expiry cycle takes priority over the timeout
    assign expire = (state_reg == ARB_WAIT) && !bus.Ack_in && (cnt_reg == CNT_LAST);

    // Timeout counter (cleared outside WAIT) and error flag of the last response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            if (state_reg != ARB_WAIT) begin
                cnt_reg <= '0;
            end else if (!bus.Ack_in) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == ARB_WAIT && bus.Ack_in) begin
                rsp_err_reg <= 1'b0;
            end else if (expire) begin
                rsp_err_reg <= 1'b1;
            end
        end
    end

    assign bus.rsp_err_out = rsp_err_reg;
`else
    assign expire          = 1'b0;
    assign bus.rsp_err_out = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        state_next       = state_reg;
        bus.ack0_out     = 1'b0;
        bus.ack1_out     = 1'b0;
        bus.resp_req_out = 1'b0;
        bus.busy_out     = (state_reg != ARB_IDLE);
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                bus.resp_req_out = 1'b1;
                if (bus.Ack_in || expire) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                bus.ack0_out = ~grant_reg;
                bus.ack1_out = grant_reg;
                state_next   = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                // Hold off until the served initiator withdraws its request
                if (grant_reg ? !bus.req1_in : !bus.req0_in) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping, request message latch and response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            auth_msg_reg   <= '0;
            rsp_msg_reg    <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_winner;
                        auth_msg_reg <= pick_winner ? bus.msg1_in : bus.msg0_in;
                    end
                end
                ARB_WAIT: begin
                    if (bus.Ack_in) begin
                        rsp_msg_reg <= bus.auth_msg_resp_in;
                    end else if (expire) begin
                        rsp_msg_reg <= '0;
                    end
                end
                ARB_DONE: begin
                    last_grant_reg <= grant_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.auth_msg_req_out = auth_msg_reg;
    assign bus.rsp_msg_out      = rsp_msg_reg;

endmodule

// File: tb/tb_auth_resp_arbiter.sv
// Scoreboard bench for auth_resp_arbiter. Honours AUTH_ARB_TIMEOUT_EN.
module tb_auth_resp_arbiter;
    import auth_resp_arbiter_pkg::*;

    localparam int MW = 8;
`ifdef AUTH_ARB_TIMEOUT_EN
    localparam int TCYC = 8;
    localparam int CW   = 4;
`else
    localparam int TCYC = AUTH_ARB_TIMEOUT;
    localparam int CW   = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    auth_resp_arbiter_if #(.MSG_W(MW)) bus ();

    auth_resp_arbiter #(.MSG_W(MW), .TIMEOUT_CYC(TCYC), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          who;
        logic [MW-1:0] rsp;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt[2] = '{0, 0};
    bit   resp_en    = 1'b1;
    int   resp_delay = 3;
    int   idx[2]     = '{0, 0};

    // Request messages and hand-computed responder answers (responder returns ~msg)
    logic [MW-1:0] msg_tbl[2][8] = '{
        '{8'h5A, 8'h11, 8'h3C, 8'h81, 8'hC6, 8'h00, 8'hFF, 8'h47},
        '{8'h22, 8'h96, 8'h0F, 8'hF0, 8'h6B, 8'h01, 8'hAA, 8'hD4}};
    logic [MW-1:0] rsp_tbl[2][8] = '{
        '{8'hA5, 8'hEE, 8'hC3, 8'h7E, 8'h39, 8'hFF, 8'h00, 8'hB8},
        '{8'hDD, 8'h69, 8'hF0, 8'h0F, 8'h94, 8'hFE, 8'h55, 8'h2B}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) bus.req0_in = v;
        else        bus.req1_in = v;
    endtask

    function automatic logic ack_of(input int i);
        return (i == 0) ? bus.ack0_out : bus.ack1_out;
    endfunction

    // Issue the next table request for initiator i and queue its expected answer
    task automatic raise(input int i);
        int k;
        k = idx[i] % 8;
        if (i == 0) bus.msg0_in = msg_tbl[0][k];
        else        bus.msg1_in = msg_tbl[1][k];
        set_req(i, 1'b1);
        sb_q.push_back('{who: (i == 1), rsp: rsp_tbl[i][k], err: 1'b0});
        $display("[TB] issue init%0d msg='h%0h expect rsp='h%0h", i, msg_tbl[i][k], rsp_tbl[i][k]);
        idx[i]++;
    endtask

    task automatic wait_ack(input int i, input string tag);
        int c = 0;
        while (!ack_of(i) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            tests++; fails++;
            $display("[TB] FAIL %s: no ack%0d within 100 cycles", tag, i);
        end
        set_req(i, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        @(negedge clk);
        while (bus.busy_out && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            tests++; fails++;
            $display("[TB] FAIL %s: busy_out stuck high", tag);
        end
    endtask

    // Run n0/n1 transactions; each initiator drops after its ack and re-requests two cycles later
    task automatic run_session(input int n0, input int n1, input string tag);
        int left[2];
        int hold[2];
        int cyc = 0;
        left = '{n0, n1};
        hold = '{0, 0};
        @(negedge clk);
        if (n0 > 0) raise(0);
        if (n1 > 0) raise(1);
        while ((left[0] > 0 || left[1] > 0 || bus.busy_out || bus.req0_in || bus.req1_in)
               && cyc < 400) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (ack_of(i)) begin
                    set_req(i, 1'b0);
                    left[i]--;
                    hold[i] = (left[i] > 0) ? 2 : 0;
                end else if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) raise(i);
                end
            end
        end
        if (cyc >= 400) begin
            tests++; fails++;
            $display("[TB] FAIL %s: session did not complete", tag);
        end
    endtask

    // Responder model: answers ~request after resp_delay WAIT cycles
    initial begin
        int wc = 0;
        bus.Ack_in           = 1'b0;
        bus.auth_msg_resp_in = '0;
        forever begin
            @(negedge clk);
            if (bus.resp_req_out && resp_en && !bus.Ack_in) begin
                if (wc == resp_delay) begin
                    bus.Ack_in           = 1'b1;
                    bus.auth_msg_resp_in = ~bus.auth_msg_req_out;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                bus.Ack_in = 1'b0;
                if (!bus.resp_req_out) wc = 0;
            end
        end
    end

    // Monitor: every ack pulse is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (bus.ack0_out || bus.ack1_out) begin
            check("ack_onehot", {31'b0, bus.ack0_out & bus.ack1_out}, 32'd0);
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_ack: ack0=%0b ack1=%0b, nothing expected",
                         bus.ack0_out, bus.ack1_out);
            end else begin
                mon_e = sb_q.pop_front();
                $display("[TB] ack init%0d rsp='h%0h err=%0b (expect init%0d 'h%0h err=%0b)",
                         bus.ack1_out, bus.rsp_msg_out, bus.rsp_err_out,
                         mon_e.who, mon_e.rsp, mon_e.err);
                check("ack_who", {31'b0, bus.ack1_out}, {31'b0, mon_e.who});
                check("rsp_msg", {24'b0, bus.rsp_msg_out}, {24'b0, mon_e.rsp});
                check("rsp_err", {31'b0, bus.rsp_err_out}, {31'b0, mon_e.err});
            end
            if (bus.ack0_out) ack_cnt[0]++;
            if (bus.ack1_out) ack_cnt[1]++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"},     {31'b0, bus.ack0_out}, 32'd0);
        check({tag, "_ack1"},     {31'b0, bus.ack1_out}, 32'd0);
        check({tag, "_rsp_msg"},  {24'b0, bus.rsp_msg_out}, 32'd0);
        check({tag, "_rsp_err"},  {31'b0, bus.rsp_err_out}, 32'd0);
        check({tag, "_busy"},     {31'b0, bus.busy_out}, 32'd0);
        check({tag, "_resp_req"}, {31'b0, bus.resp_req_out}, 32'd0);
        check({tag, "_auth_msg"}, {24'b0, bus.auth_msg_req_out}, 32'd0);
    endtask

    initial begin
        int a0;
        int c;
        bus.req0_in = 1'b0;
        bus.req1_in = 1'b0;
        bus.msg0_in = '0;
        bus.msg1_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single request from initiator 0
        @(negedge clk);
        raise(0);
        check("t1_req_latency0", {31'b0, bus.resp_req_out}, 32'd0);
        @(negedge clk);
        check("t1_req_latency1", {31'b0, bus.resp_req_out}, 32'd1);
        check("t1_auth_msg", {24'b0, bus.auth_msg_req_out}, 32'h5A);
        check("t1_busy", {31'b0, bus.busy_out}, 32'd1);
        wait_ack(0, "t1_ack");
        wait_idle("t1_idle");
        check("t1_ack0_count", ack_cnt[0], 32'd1);
        check("t1_ack1_never", ack_cnt[1], 32'd0);

        // Tie: initiator 0 served before 1 (last served was 0, so reset first)
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_session(1, 1, "t2_tie");

        // Fairness: both keep requesting, grants alternate 0,1,0,1
        run_session(2, 2, "t3_fair");

        // Stale request: req0 held 5 cycles after its ack
        @(negedge clk);
        a0 = ack_cnt[0];
        raise(0);
        wait_ack(0, "t4_ack");
        set_req(0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_busy_release", {31'b0, bus.busy_out}, 32'd1);
            check("t4_no_regrant", {31'b0, bus.resp_req_out}, 32'd0);
        end
        set_req(0, 1'b0);
        @(negedge clk);
        check("t4_idle_after_drop", {31'b0, bus.busy_out}, 32'd0);
        check("t4_single_ack", ack_cnt[0] - a0, 32'd1);

        // Reset asserted mid-WAIT
        resp_en = 1'b0;
        bus.msg0_in = 8'h77;
        bus.req0_in = 1'b1;
        @(negedge clk);
        check("t5_in_wait", {31'b0, bus.resp_req_out}, 32'd1);
        a0 = ack_cnt[0] + ack_cnt[1];
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_async");
        bus.req0_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        check("t5_no_ack", ack_cnt[0] + ack_cnt[1] - a0, 32'd0);
        run_session(1, 1, "t5_tie_after_reset");

`ifdef AUTH_ARB_TIMEOUT_EN
        // Timeout: no Ack, 8 WAIT cycles then error ack
        resp_en = 1'b0;
        @(negedge clk);
        bus.msg1_in = 8'h3B;
        bus.req1_in = 1'b1;
        sb_q.push_back('{who: 1'b1, rsp: 8'h00, err: 1'b1});
        @(negedge clk);
        c = 0;
        while (bus.resp_req_out && c < 50) begin
            c++;
            @(negedge clk);
        end
        check("t6_wait_cycles", c, 32'd8);
        check("t6_ack1_err", {31'b0, bus.ack1_out}, 32'd1);
        bus.req1_in = 1'b0;
        wait_idle("t6_idle");
        // Ack in the expiry cycle wins
        resp_en    = 1'b1;
        resp_delay = TCYC - 1;
        @(negedge clk);
        raise(1);
        wait_ack(1, "t6_ack_on_expiry");
        wait_idle("t6_idle2");
`else
        // No timeout: a slow responder keeps WAIT alive
        resp_delay = 20;
        @(negedge clk);
        raise(0);
        repeat (16) @(negedge clk);
        check("t6_still_waiting", {31'b0, bus.resp_req_out}, 32'd1);
        wait_ack(0, "t6_slow_ack");
        wait_idle("t6_idle");
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
